// File: rtl/alu_in2_fwd_ctrl.sv
// Operand-2 forwarding select and load-use stall control for the EX-stage ALU input-2 mux.
// Optional stall counter enabled by defining ALU_IN2_STALL_CNT_EN.
module alu_in2_fwd_ctrl #(
  parameter int REG_ADDR_W  = 5,
  parameter int STALL_CNT_W = 16
) (
  input  logic                  Clk,
  input  logic                  Reset_n,
  input  logic                  IssueValid,
  input  logic                  IssueUsesRt,
  input  logic [REG_ADDR_W-1:0] IssueRt,
  input  logic [REG_ADDR_W-1:0] IssueDst,
  input  logic                  IssueRegWrite,
  input  logic                  IssueMemRead,
  input  logic                  Flush,
  input  logic                  Hold,
  output logic                  Stall,
`ifdef ALU_IN2_STALL_CNT_EN
  output logic [STALL_CNT_W-1:0] StallCount,
`endif
  output logic [1:0]            ALUIn2Sel
);

  typedef struct packed {
    logic                  valid;
    logic                  regwrite;
    logic                  memread;
    logic [REG_ADDR_W-1:0] dst;
  } slot_t;

  slot_t ex_q, ex_d;
  // The MEM slot only needs producer identity; whether it was a load no longer matters there.
  logic                  mem_vld_q, mem_wr_q;
  logic [REG_ADDR_W-1:0] mem_dst_q;
  logic [1:0]            sel_q, sel_d;
  logic                  hit_ex, hit_mem, bubble;

  always_comb begin
    hit_ex  = ex_q.valid & ex_q.regwrite & (ex_q.dst == IssueRt) & (IssueRt != '0);
    hit_mem = mem_vld_q & mem_wr_q & (mem_dst_q == IssueRt) & (IssueRt != '0);
    Stall   = IssueValid & IssueUsesRt & hit_ex & ex_q.memread & ~Flush;
    bubble  = ~IssueValid | Stall | Flush;

    sel_d = 2'b00;
    if (!bubble && IssueUsesRt) begin
      if (hit_ex)       sel_d = 2'b01;
      else if (hit_mem) sel_d = 2'b10;
    end

    ex_d = '0;
    if (!bubble) begin
      ex_d.valid    = 1'b1;
      ex_d.regwrite = IssueRegWrite;
      ex_d.memread  = IssueMemRead;
      ex_d.dst      = IssueDst;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      ex_q      <= '0;
      mem_vld_q <= 1'b0;
      mem_wr_q  <= 1'b0;
      mem_dst_q <= '0;
      sel_q     <= 2'b00;
    end else if (!Hold) begin
      mem_vld_q <= ex_q.valid;
      mem_wr_q  <= ex_q.regwrite;
      mem_dst_q <= ex_q.dst;
      ex_q      <= ex_d;
      sel_q     <= sel_d;
    end
  end

  assign ALUIn2Sel = sel_q;

`ifdef ALU_IN2_STALL_CNT_EN
  logic [STALL_CNT_W-1:0] cnt_q;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n)
      cnt_q <= '0;
    else if (!Hold && Stall && (cnt_q != {STALL_CNT_W{1'b1}}))
      cnt_q <= cnt_q + 1'b1;
  end

  assign StallCount = cnt_q;
`endif

endmodule

// File: tb/tb_alu_in2_fwd_ctrl.sv
// Directed plus randomized bench for alu_in2_fwd_ctrl against an in-flight instruction history model.
module tb_alu_in2_fwd_ctrl;
  logic       Clk = 1'b0;
  logic       Reset_n = 1'b0;
  logic       IssueValid = 1'b0, IssueUsesRt = 1'b0, IssueRegWrite = 1'b0, IssueMemRead = 1'b0;
  logic [4:0] IssueRt = '0, IssueDst = '0;
  logic       Flush = 1'b0, Hold = 1'b0;
  logic       Stall;
  logic [1:0] ALUIn2Sel;
`ifdef ALU_IN2_STALL_CNT_EN
  logic [15:0] StallCount;
`endif

  alu_in2_fwd_ctrl dut (
    .Clk(Clk), .Reset_n(Reset_n), .IssueValid(IssueValid), .IssueUsesRt(IssueUsesRt),
    .IssueRt(IssueRt), .IssueDst(IssueDst), .IssueRegWrite(IssueRegWrite),
    .IssueMemRead(IssueMemRead), .Flush(Flush), .Hold(Hold), .Stall(Stall),
`ifdef ALU_IN2_STALL_CNT_EN
    .StallCount(StallCount),
`endif
    .ALUIn2Sel(ALUIn2Sel)
  );

  always #5 Clk = ~Clk;

  // History of instructions in flight: [0] is in EX, [1] is in MEM.
  typedef struct {bit v; bit rw; bit mr; bit [4:0] dst;} ins_t;
  ins_t pipe[2];
  bit [1:0] exp_sel;
  int exp_cnt;
  int passed = 0, total = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) pipe[i] = '{1'b0, 1'b0, 1'b0, 5'd0};
    exp_sel = 2'b00;
    exp_cnt = 0;
  endtask

  task automatic chk_cnt(input string tag);
`ifdef ALU_IN2_STALL_CNT_EN
    chk({tag, ".cnt"}, {16'd0, StallCount}, exp_cnt);
`endif
  endtask

  task automatic step(input bit v, input bit u, input bit [4:0] rt, input bit [4:0] dst,
                      input bit rw, input bit mr, input bit fl, input bit hd, input string tag);
    bit es, bubble, found;
    bit [1:0] nsel;
    IssueValid = v; IssueUsesRt = u; IssueRt = rt; IssueDst = dst;
    IssueRegWrite = rw; IssueMemRead = mr; Flush = fl; Hold = hd;
    @(negedge Clk);
    // A load still in EX cannot supply its data yet to the instruction reading it.
    es = v && u && rt != 0 && pipe[0].v && pipe[0].rw && pipe[0].mr && pipe[0].dst == rt && !fl;
    chk({tag, ".stall"}, {31'd0, Stall}, {31'd0, es});
    @(posedge Clk);
    if (!hd) begin
      bubble = !v || es || fl;
      nsel = 2'b00;
      found = 1'b0;
      if (!bubble && u && rt != 0)
        for (int i = 0; i < 2; i++)
          if (!found && pipe[i].v && pipe[i].rw && pipe[i].dst == rt) begin
            nsel = 2'(i + 1);
            found = 1'b1;
          end
      if (es && exp_cnt != 65535) exp_cnt++;
      pipe[1] = pipe[0];
      pipe[0] = bubble ? '{1'b0, 1'b0, 1'b0, 5'd0} : '{1'b1, rw, mr, dst};
      exp_sel = nsel;
    end
    #1;
    chk({tag, ".sel"}, {30'd0, ALUIn2Sel}, {30'd0, exp_sel});
    chk_cnt(tag);
  endtask

  initial begin
    model_reset();
    #2;
    chk("rst.sel", {30'd0, ALUIn2Sel}, 32'd0);
    chk("rst.stall", {31'd0, Stall}, 32'd0);
    chk_cnt("rst");
    @(posedge Clk); #1;
    Reset_n = 1'b1;

    //   v  u  rt  dst rw mr fl hd
    step(1, 0, 0,  5,  1, 0, 0, 0, "exf.prod");
    step(1, 1, 5,  6,  1, 0, 0, 0, "exf.use");
    chk("exf.sel01", {30'd0, ALUIn2Sel}, 32'd1);

    step(1, 0, 0,  7,  1, 0, 0, 0, "pri.p1");
    step(1, 0, 0,  7,  1, 0, 0, 0, "pri.p2");
    step(1, 1, 7,  8,  1, 0, 0, 0, "pri.use");
    chk("pri.sel01", {30'd0, ALUIn2Sel}, 32'd1);
    step(1, 0, 0,  7,  1, 0, 0, 0, "memf.p1");
    step(1, 0, 0,  3,  1, 0, 0, 0, "memf.p2");
    step(1, 1, 7,  8,  1, 0, 0, 0, "memf.use");
    chk("memf.sel10", {30'd0, ALUIn2Sel}, 32'd2);

    step(1, 0, 0,  9,  1, 1, 0, 0, "lu.lw");
    step(1, 1, 9, 10,  1, 0, 0, 0, "lu.stall");
    chk("lu.bubble", {30'd0, ALUIn2Sel}, 32'd0);
    step(1, 1, 9, 10,  1, 0, 0, 0, "lu.issue");
    chk("lu.sel10", {30'd0, ALUIn2Sel}, 32'd2);

    step(1, 0, 0,  0,  1, 0, 0, 0, "r0.prod");
    step(1, 1, 0, 11,  1, 0, 0, 0, "r0.use");
    step(1, 0, 0,  4,  1, 1, 0, 0, "imm.lw");
    step(1, 0, 4, 12,  1, 0, 0, 0, "imm.use");

    step(1, 0, 0,  2,  1, 1, 0, 0, "hold.lw");
    for (int i = 0; i < 3; i++) step(1, 1, 2, 13, 1, 0, 0, 1, "hold.frz");
    step(1, 1, 2, 13,  1, 0, 0, 0, "hold.rel");
    step(1, 1, 2, 13,  1, 0, 0, 0, "hold.issue");

    step(1, 0, 0,  2,  1, 1, 0, 0, "fl.lw");
    step(1, 1, 2, 14,  1, 0, 1, 0, "fl.flush");
    chk("fl.sel00", {30'd0, ALUIn2Sel}, 32'd0);

    // Asynchronous reset while a load-use stall is being presented.
    step(1, 0, 0,  3,  1, 1, 0, 0, "mrst.lw");
    IssueValid = 1; IssueUsesRt = 1; IssueRt = 5'd3; IssueDst = 5'd15;
    IssueRegWrite = 1; IssueMemRead = 0; Flush = 0; Hold = 0;
    #2;
    chk("mrst.pre", {31'd0, Stall}, 32'd1);
    Reset_n = 1'b0;
    model_reset();
    #1;
    chk("mrst.stall", {31'd0, Stall}, 32'd0);
    chk("mrst.sel", {30'd0, ALUIn2Sel}, 32'd0);
    chk_cnt("mrst");
    @(posedge Clk); #1;
    Reset_n = 1'b1;

    for (int n = 0; n < 400; n++)
      step($urandom_range(0, 7) != 0, $urandom_range(0, 3) != 0,
           5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
           $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
           $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0, "rnd");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
